// File: rtl/pri_scan_encoder.sv
// Sequential priority encoder: captures a request vector and emits the index of
// every set bit, one per valid/ready transfer, in configurable priority order.
module pri_scan_encoder #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = $clog2(N),
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] x,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         idc,
  output logic         busy,
  output logic         done,
  output logic [W:0]   count
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic [W:0]   count_nxt;
  logic         done_nxt;
  logic [W-1:0] sel;

  // Priority pick over the pending vector; the last match in loop order wins.
  always_comb begin
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (pending[i]) sel = W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (pending[i]) sel = W'(i);
      end
    end
  end

  assign busy    = (state == SCAN);
  assign y_valid = busy && en;
  assign y       = y_valid ? sel : '0;
  assign idc     = en && (|pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      count   <= count_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    count_nxt   = count;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (load && en) begin
          pending_nxt = x;
          count_nxt   = '0;
          if (|x) state_nxt = SCAN;
          else    done_nxt  = 1'b1;
        end
      end
      SCAN: begin
        // Transfer: retire the current index; finishing the last one ends the job.
        if (y_valid && y_ready) begin
          pending_nxt[sel] = 1'b0;
          count_nxt        = count + (W+1)'(1);
          if (pending_nxt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pri_scan_encoder.sv
// Randomized and directed bench for pri_scan_encoder; three configurations are
// checked every cycle against an index-list reference model.
module tb_pri_scan_encoder;

  logic        clk = 1'b0;
  logic        rst, en, load, y_ready;
  logic [15:0] x;

  // a: N=8 MSB first, b: N=8 LSB first, c: N=16 MSB first
  logic [2:0] y_a, y_b;
  logic [3:0] y_c;
  logic [3:0] cnt_a, cnt_b;
  logic [4:0] cnt_c;
  logic yv_a, yv_b, yv_c, idc_a, idc_b, idc_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per instance, the job's indices in emission order.
  int lst [3][16];
  int head [3];
  int len [3];
  int cnt [3];
  bit act [3];
  bit dn [3];

  always #5 clk = ~clk;

  pri_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .x(x[7:0]), .y(y_a), .y_valid(yv_a),
    .y_ready(y_ready), .idc(idc_a), .busy(busy_a), .done(done_a), .count(cnt_a));
  pri_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .x(x[7:0]), .y(y_b), .y_valid(yv_b),
    .y_ready(y_ready), .idc(idc_b), .busy(busy_b), .done(done_b), .count(cnt_b));
  pri_scan_encoder #(.N(16), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .x(x), .y(y_c), .y_valid(yv_c),
    .y_ready(y_ready), .idc(idc_c), .busy(busy_c), .done(done_c), .count(cnt_c));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      head[k] = 0; len[k] = 0; cnt[k] = 0; act[k] = 0; dn[k] = 0;
    end
  endtask

  task automatic model_edge(input bit e, input bit l, input bit rd, input logic [15:0] xv);
    for (int k = 0; k < 3; k++) begin
      int  nk = (k == 2) ? 16 : 8;
      bit  msb = (k != 1);
      bit  dnn = 0;
      if (!act[k]) begin
        if (l && e) begin
          len[k] = 0; head[k] = 0; cnt[k] = 0;
          for (int j = 0; j < nk; j++) begin
            int b = msb ? nk - 1 - j : j;
            if (xv[b]) begin
              lst[k][len[k]] = b;
              len[k]++;
            end
          end
          if (len[k] > 0) act[k] = 1;
          else            dnn = 1;
        end
      end else if (e && rd) begin
        head[k]++;
        cnt[k]++;
        if (head[k] == len[k]) begin
          act[k] = 0;
          dnn = 1;
        end
      end
      dn[k] = dnn;
    end
  endtask

  task automatic check_dut(input int k, input string nm, input int y, input int yv,
                           input int idc, input int busy, input int done, input int c,
                           input bit e);
    int ev = (act[k] && e) ? 1 : 0;
    chk({nm, "_y"}, y, ev ? lst[k][head[k]] : 0);
    chk({nm, "_y_valid"}, yv, ev);
    chk({nm, "_idc"}, idc, (e && (len[k] - head[k] > 0)) ? 1 : 0);
    chk({nm, "_busy"}, busy, act[k] ? 1 : 0);
    chk({nm, "_done"}, done, dn[k] ? 1 : 0);
    chk({nm, "_count"}, c, cnt[k]);
  endtask

  // One cycle: apply inputs after the falling edge, check, then advance the model.
  task automatic step(input bit r, input bit e, input bit l, input logic [15:0] xv, input bit rd);
    @(negedge clk);
    rst = r; en = e; load = l; x = xv; y_ready = rd;
    #1;
    if (r) model_reset();
    check_dut(0, "a", int'(y_a), int'(yv_a), int'(idc_a), int'(busy_a), int'(done_a), int'(cnt_a), e);
    check_dut(1, "b", int'(y_b), int'(yv_b), int'(idc_b), int'(busy_b), int'(done_b), int'(cnt_b), e);
    check_dut(2, "c", int'(y_c), int'(yv_c), int'(idc_c), int'(busy_c), int'(done_c), int'(cnt_c), e);
    if (!r) model_edge(e, l, rd, xv);
  endtask

  initial begin
    int e1 [3];
    int e2 [3];
    logic [15:0] xr;
    e1 = '{7, 5, 2};
    e2 = '{2, 5, 7};
    rst = 1'b1; en = 1'b0; load = 1'b0; x = '0; y_ready = 1'b0;
    model_reset();
    step(1, 0, 0, 16'h0, 0);
    step(1, 1, 1, 16'hFFFF, 1);
    step(0, 1, 0, 16'h0, 0);

    // Basic scan in both priority directions
    step(0, 1, 1, 16'h00A4, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 16'h0, 1);
      chk("tp1_y_msb", int'(y_a), e1[i]);
      chk("tp1_y_lsb", int'(y_b), e2[i]);
    end
    step(0, 1, 0, 16'h0, 1);
    chk("tp1_done", int'(done_a), 1);
    chk("tp1_count", int'(cnt_b), 3);
    chk("tp1_busy", int'(busy_a), 0);

    // Backpressure with an ignored load during SCAN
    step(0, 1, 1, 16'h0011, 0);
    step(0, 1, 0, 16'h0, 0);
    chk("bp_y_hold", int'(y_a), 4);
    step(0, 1, 1, 16'hFFFF, 0);
    step(0, 1, 0, 16'h0, 0);
    chk("bp_y_hold2", int'(y_a), 4);
    step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    chk("bp_y_next", int'(y_a), 0);
    step(0, 1, 0, 16'h0, 0);
    chk("bp_done", int'(done_a), 1);
    chk("bp_count", int'(cnt_a), 2);

    // Empty vector
    step(0, 1, 1, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    chk("empty_done", int'(done_c), 1);
    chk("empty_valid", int'(yv_c), 0);
    step(0, 1, 0, 16'h0, 1);
    chk("empty_done_once", int'(done_c), 0);

    // Pause, then a reset mid-scan
    step(0, 1, 1, 16'h8001, 1);
    step(0, 1, 0, 16'h0, 1);
    chk("pause_y15", int'(y_c), 15);
    step(0, 0, 0, 16'h0, 1);
    chk("pause_idc", int'(idc_c), 0);
    step(0, 0, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    chk("pause_resume_y", int'(y_c), 0);
    step(0, 1, 0, 16'h0, 1);
    chk("pause_done", int'(done_c), 1);
    step(0, 1, 1, 16'h8001, 1);
    step(0, 1, 0, 16'h0, 0);
    step(1, 1, 0, 16'h0, 0);
    chk("rst_busy", int'(busy_c), 0);
    step(0, 1, 0, 16'h0, 0);
    chk("rst_no_done", int'(done_c), 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(3))
        0:       xr = '0;
        1:       xr = 16'(1) << $urandom_range(15);
        2:       xr = 16'($urandom) & 16'($urandom);
        default: xr = 16'($urandom);
      endcase
      step(($urandom_range(99) == 0), ($urandom_range(9) != 0), ($urandom_range(2) == 0),
           xr, ($urandom_range(4) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pri_scan_encoder.md
Name: pri_scan_encoder

Overview:
Parametrised, sequential priority encoder. Captures an N-bit request vector and emits the index of every set bit, one per accepted transfer, in priority order over a valid/ready handshake. Pulses done when the vector is exhausted. Generalises the 8-to-3 enabled encoder: width, priority direction and multi-hit scanning are configurable. Sits between request collectors (interrupt/flag vectors) and downstream consumers that service one index at a time.

Parameters:
N, 8, request vector width; N >= 2.
W, $clog2(N), index width (derived; do not override).
MSB_FIRST, 1, 1 = highest set index has priority; 0 = lowest set index has priority.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  global enable; 0 pauses scanning and blocks load.
load  input  1  capture x when idle and enabled.
x  input  N  request vector.
y  output  W  current priority index; 0 when y_valid = 0.
y_valid  output  1  y holds a valid index.
y_ready  input  1  consumer accepts y this cycle.
idc  output  1  en && (pending != 0); any request outstanding.
busy  output  1  1 while in SCAN.
done  output  1  one-cycle pulse when a job completes.
count  output  W+1  indices emitted in current/last job.

Behaviour:
- Reset (async, rst=1): state IDLE, pending = 0, count = 0, done = 0; therefore y = 0, y_valid = 0, idc = 0, busy = 0. An in-flight job is discarded with no done pulse.
- Internal state: pending register (N bits), state in {IDLE, SCAN}.
- IDLE: busy = 0, y_valid = 0. On the edge where load && en: pending <= x, count <= 0.
  - If x != 0: next state SCAN.
  - If x == 0: stay IDLE; done = 1 in the following cycle, count = 0.
- load with en = 0 is ignored in every state. load in SCAN is ignored; the pending vector is not modified.
- SCAN: busy = 1. y = index of highest set bit of pending if MSB_FIRST = 1, else lowest. y_valid = en. y is combinational from the pending register.
- Latency: load at edge t gives y_valid = 1 in cycle t+1, i.e. one cycle.
- Transfer occurs when y_valid && y_ready at a rising edge. On transfer: clear pending[y] and count <= count + 1.
  - If that bit was the last set bit: next state IDLE, done = 1 for exactly the next cycle.
- Throughput: one index per cycle with y_ready held high. y and y_valid stay stable while y_ready = 0.
- en = 0 in SCAN: y_valid = 0, y = 0, no transfer; pending, count and state hold. Scanning resumes at the same index when en returns to 1.
- done is registered and lasts 1 cycle. A load on the same cycle done is high is accepted normally, because state is already IDLE.
- count saturates naturally: at most N, which fits in W+1 bits. count holds its value in IDLE until the next accepted load.
- idc is combinational: en && |pending.

Test Plan:
- N=8, MSB_FIRST=1, load x=8'b1010_0100, y_ready=1 -> y = 7, 5, 2 on three consecutive cycles starting 1 cycle after load; done pulses the cycle after y=2 is accepted; count=3; busy falls with done.
- Same stimulus with MSB_FIRST=0 -> y = 2, 5, 7; done and count=3 as above.
- Backpressure: x=8'b0001_0001, MSB_FIRST=1, y_ready low for 3 cycles -> y holds 4 with y_valid=1; on y_ready=1 -> next y=0, then done; count=2. A load pulse with x=8'hFF during SCAN is ignored and the emitted sequence is unchanged.
- Empty vector: load x=0 -> y_valid never asserts; done=1 exactly one cycle after load; count=0; idc=0.
- Pause and reset: N=16, x=16'h8001, MSB_FIRST=1. After y=15 is accepted, drop en for 2 cycles -> y_valid=0, idc=0, state holds. Re-enable -> y=0, then done. Repeat the run and assert rst mid-scan -> all outputs 0 immediately, no done pulse.
